// File: rtl/mario_sound_mix_filter.sv
// Sound back end: captures asynchronous 8-bit DAC writes, applies per-channel gain and a
// time-multiplexed first-order IIR low-pass on one shared multiplier, then mixes to 16 bits.
module mario_sound_mix_filter #(
  parameter int CHANNELS = 2,
  parameter int DIV      = 500,
  parameter int COEF_W   = 18,
  parameter int A2       = -28065,
  parameter int B1       = 2352,
  parameter int B2       = 2352
) (
  input  logic                       I_CLK_24M,
  input  logic                       I_RST,
  input  logic [CHANNELS-1:0]        I_WRn,
  input  logic [8*CHANNELS-1:0]      I_DATA,
  input  logic [4*CHANNELS-1:0]      I_GAIN,
  output logic [16*CHANNELS-1:0]     O_CH_DAC,
  output logic signed [15:0]         O_SND_OUT,
  output logic                       O_SND_VLD,
  output logic                       O_OVERRUN
);

  localparam int ACC_W = 16 + COEF_W + 2;
  localparam int SUM_W = 16 + $clog2(CHANNELS) + 1;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SAT_W = 64;

  localparam logic signed [COEF_W-1:0] C_B1  = COEF_W'(B1);
  localparam logic signed [COEF_W-1:0] C_B2  = COEF_W'(B2);
  localparam logic signed [COEF_W-1:0] C_A2N = COEF_W'(-A2);
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CH_W-1:0]          CH_LAST  = CH_W'(CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SNAP = 3'd1,
    S_M0   = 3'd2,
    S_M1   = 3'd3,
    S_M2   = 3'd4,
    S_ST   = 3'd5,
    S_MIX  = 3'd6
  } state_e;

  function automatic logic signed [15:0] sat16(input logic signed [SAT_W-1:0] v);
    logic signed [15:0] r;
    if (v > 64'sd32767) begin
      r = 16'sh7FFF;
    end else if (v < -64'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  function automatic logic [15:0] dac_conv(input logic [7:0] d);
    return {~d[7], d[6:0], ~d[7], d[6:0]};
  endfunction

  logic [CHANNELS-1:0]     wr_s1_q, wr_s2_q, wr_s3_q;
  logic [8*CHANNELS-1:0]   hold_q;
  logic [16*CHANNELS-1:0]  dac_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    tick_s;

  state_e                  state_q;
  logic [CH_W-1:0]         ch_q;
  logic signed [15:0]      xsnap_q [CHANNELS];
  logic [3:0]              gsnap_q [CHANNELS];
  logic signed [15:0]      x1_q    [CHANNELS];
  logic signed [15:0]      y1_q    [CHANNELS];
  logic signed [ACC_W-1:0] acc_q;
  logic signed [SUM_W-1:0] sum_q;
  logic signed [15:0]      out_q;
  logic                    vld_q;
  logic                    ovr_q;

  logic signed [15:0]      x_cur_s;
  logic [3:0]              g_cur_s;
  logic signed [20:0]      xgain_s;
  logic signed [15:0]      xg_s;
  logic signed [COEF_W-1:0] coef_s;
  logic signed [15:0]      opnd_s;
  logic signed [ACC_W-1:0] prod_s;
  logic signed [15:0]      y_s;
  logic signed [SUM_W-1:0] sum_d;

  // Write strobes are synchronised; the DAC register loads when the write ends.
  always_ff @(posedge I_CLK_24M or negedge I_RST) begin
    if (!I_RST) begin
      wr_s1_q <= {CHANNELS{1'b1}};
      wr_s2_q <= {CHANNELS{1'b1}};
      wr_s3_q <= {CHANNELS{1'b1}};
      hold_q  <= {(8*CHANNELS){1'b0}};
      dac_q   <= {(16*CHANNELS){1'b0}};
    end else begin
      wr_s1_q <= I_WRn;
      wr_s2_q <= wr_s1_q;
      wr_s3_q <= wr_s2_q;
      for (int c = 0; c < CHANNELS; c++) begin
        if (!wr_s1_q[c]) begin
          hold_q[8*c +: 8] <= I_DATA[8*c +: 8];
        end
        if (wr_s2_q[c] && !wr_s3_q[c]) begin
          dac_q[16*c +: 16] <= dac_conv(hold_q[8*c +: 8]);
        end
      end
    end
  end

  assign tick_s = (cnt_q == CNT_LAST);

  // Sample-rate divider.
  always_ff @(posedge I_CLK_24M or negedge I_RST) begin
    if (!I_RST) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (tick_s) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign x_cur_s = xsnap_q[ch_q];
  assign g_cur_s = gsnap_q[ch_q];
  assign xgain_s = 21'(x_cur_s) * 21'($signed({1'b0, g_cur_s}));
  assign xg_s    = sat16(SAT_W'(xgain_s >>> 3));

  // Operand select for the single filter multiplier.
  always_comb begin
    coef_s = C_B1;
    opnd_s = xg_s;
    case (state_q)
      S_M1: begin
        coef_s = C_B2;
        opnd_s = x1_q[ch_q];
      end
      S_M2: begin
        coef_s = C_A2N;
        opnd_s = y1_q[ch_q];
      end
      default: begin
        coef_s = C_B1;
        opnd_s = xg_s;
      end
    endcase
  end

  assign prod_s = ACC_W'(coef_s) * ACC_W'(opnd_s);
  assign y_s    = sat16(SAT_W'(acc_q >>> 15));
  assign sum_d  = sum_q + SUM_W'(y_s);

  // Frame sequencer; the mix result and its strobe are registered on the last store so
  // both are visible together in the MIX cycle.
  always_ff @(posedge I_CLK_24M or negedge I_RST) begin
    if (!I_RST) begin
      state_q <= S_IDLE;
      ch_q    <= {CH_W{1'b0}};
      acc_q   <= {ACC_W{1'b0}};
      sum_q   <= {SUM_W{1'b0}};
      out_q   <= 16'sd0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        xsnap_q[c] <= 16'sd0;
        gsnap_q[c] <= 4'd0;
        x1_q[c]    <= 16'sd0;
        y1_q[c]    <= 16'sd0;
      end
    end else begin
      vld_q <= 1'b0;
      if (tick_s && (state_q != S_IDLE)) begin
        ovr_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (tick_s) begin
            state_q <= S_SNAP;
          end
        end
        S_SNAP: begin
          for (int c = 0; c < CHANNELS; c++) begin
            xsnap_q[c] <= $signed(dac_q[16*c +: 16]);
            gsnap_q[c] <= I_GAIN[4*c +: 4];
          end
          sum_q   <= {SUM_W{1'b0}};
          ch_q    <= {CH_W{1'b0}};
          state_q <= S_M0;
        end
        S_M0: begin
          acc_q   <= prod_s;
          state_q <= S_M1;
        end
        S_M1: begin
          acc_q   <= acc_q + prod_s;
          state_q <= S_M2;
        end
        S_M2: begin
          acc_q   <= acc_q + prod_s;
          state_q <= S_ST;
        end
        S_ST: begin
          x1_q[ch_q] <= xg_s;
          y1_q[ch_q] <= y_s;
          sum_q      <= sum_d;
          if (ch_q == CH_LAST) begin
            out_q   <= sat16(SAT_W'(sum_d));
            vld_q   <= 1'b1;
            state_q <= S_MIX;
          end else begin
            ch_q    <= ch_q + CH_W'(1);
            state_q <= S_M0;
          end
        end
        S_MIX: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign O_CH_DAC  = dac_q;
  assign O_SND_OUT = out_q;
  assign O_SND_VLD = vld_q;
  assign O_OVERRUN = ovr_q;

endmodule

// File: tb/tb_mario_sound_mix_filter.sv
// Randomized DAC writes and gains checked against a frame-level arithmetic model of the mixer.
module tb_mario_sound_mix_filter;
  localparam int CH    = 2;
  localparam int DIV   = 24;
  localparam int DIV_B = 8;
  localparam int LAT   = DIV + 4*CH + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              rst_n = 1'b0;
  logic [CH-1:0]     wrn   = {CH{1'b1}};
  logic [8*CH-1:0]   data  = {(8*CH){1'b0}};
  logic [4*CH-1:0]   gain  = {(4*CH){1'b0}};
  logic [16*CH-1:0]  ch_dac;
  logic signed [15:0] snd;
  logic              vld, ovr;

  logic              rst_b  = 1'b0;
  logic [CH-1:0]     wrn_b  = {CH{1'b1}};
  logic [8*CH-1:0]   data_b = {(8*CH){1'b0}};
  logic [4*CH-1:0]   gain_b = {(4*CH){1'b0}};
  logic [16*CH-1:0]  ch_dac_b;
  logic signed [15:0] snd_b;
  logic              vld_b, ovr_b;

  mario_sound_mix_filter #(.CHANNELS(CH), .DIV(DIV)) dut (
    .I_CLK_24M(clk), .I_RST(rst_n), .I_WRn(wrn), .I_DATA(data), .I_GAIN(gain),
    .O_CH_DAC(ch_dac), .O_SND_OUT(snd), .O_SND_VLD(vld), .O_OVERRUN(ovr));

  mario_sound_mix_filter #(.CHANNELS(CH), .DIV(DIV_B)) dut_b (
    .I_CLK_24M(clk), .I_RST(rst_b), .I_WRn(wrn_b), .I_DATA(data_b), .I_GAIN(gain_b),
    .O_CH_DAC(ch_dac_b), .O_SND_OUT(snd_b), .O_SND_VLD(vld_b), .O_OVERRUN(ovr_b));

  int tests = 0;
  int fails = 0;
  int last_vld = 0;
  int m_dac[CH], m_gain[CH], m_x1[CH], m_y1[CH];

  function automatic int sat(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Offset-binary byte to signed: high byte is the signed sample, low byte repeats it.
  function automatic int dac_val(int d);
    int s;
    s = d - 128;
    return s * 256 + (s & 255);
  endfunction

  function automatic int model_frame();
    longint sum;
    sum = 0;
    for (int c = 0; c < CH; c++) begin
      longint xg, acc;
      int y;
      xg  = sat((longint'(m_dac[c]) * m_gain[c]) >>> 3);
      acc = 2352 * xg + 2352 * longint'(m_x1[c]) + 28065 * longint'(m_y1[c]);
      y   = sat(acc >>> 15);
      m_x1[c] = int'(xg);
      m_y1[c] = y;
      sum += y;
    end
    return sat(sum);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m_dac[c] = 0; m_x1[c] = 0; m_y1[c] = 0;
    end
  endtask

  task automatic next_frame(output int out, output bit ok, output int at);
    ok = 1'b0; out = 0; at = 0;
    for (int i = 0; i < 3*DIV; i++) begin
      @(negedge clk);
      if (vld === 1'b1) begin
        ok = 1'b1; out = int'(snd); at = cyc;
        break;
      end
    end
  endtask

  task automatic dac_write(input logic [CH-1:0] mask, input logic [8*CH-1:0] d);
    @(negedge clk);
    data = d;
    wrn  = ~mask;
    repeat (3) @(negedge clk);
    wrn = {CH{1'b1}};
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int out, at, start, exp;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wrn  = i[0] ? {CH{1'b0}} : {CH{1'b1}};
      data = 16'($urandom);
      tests++;
      if (ch_dac !== 32'h0 || snd !== 16'sd0 || vld !== 1'b0 || ovr !== 1'b0 ||
          vld_b !== 1'b0 || ovr_b !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: dac=%h out=%0d vld=%b ovr=%b, want all 0", ch_dac, snd, vld, ovr);
      end
    end
    wrn = {CH{1'b1}};
    @(negedge clk);
    rst_n = 1'b1;
    start = cyc;
    model_clear();
    next_frame(out, ok, at);
    tests++;
    if (!ok || (at - start) !== LAT) begin
      fails++;
      $display("FAIL reset_first_vld: cycle %0d (seen=%b), want %0d", at - start, ok, LAT);
    end
    exp = model_frame();
    tests++;
    if (out !== exp) begin
      fails++;
      $display("FAIL reset_first_out: got %0d want %0d", out, exp);
    end
    last_vld = at;
  endtask

  task automatic test_step();
    int out, at, exp;
    bit ok;
    gain = {4'd8, 4'd8}; m_gain[0] = 8; m_gain[1] = 8;
    dac_write(2'b01, {8'h80, 8'hFF});
    m_dac[0] = dac_val(8'hFF);
    repeat (2) @(negedge clk);
    tests++;
    if (ch_dac[15:0] !== 16'(m_dac[0]) || ch_dac[15:0] !== 16'h7F7F) begin
      fails++;
      $display("FAIL step_dac: got %h want 7f7f", ch_dac[15:0]);
    end
    for (int f = 0; f < 60; f++) begin
      next_frame(out, ok, at);
      tests++;
      if (!ok) begin fails++; $display("FAIL step_timeout: frame %0d no VLD", f); return; end
      exp = model_frame();
      if (f == 0) begin
        tests++;
        if (out !== 2342) begin fails++; $display("FAIL step_first: got %0d want 2342", out); end
      end
      tests++;
      if (out !== exp) begin fails++; $display("FAIL step_out: frame %0d got %0d want %0d", f, out, exp); end
      tests++;
      if (at - last_vld !== DIV) begin fails++; $display("FAIL step_period: got %0d want %0d", at - last_vld, DIV); end
      last_vld = at;
    end
    tests++;
    if (out < 32639 - 8 || out > 32639 + 8) begin
      fails++;
      $display("FAIL step_settle: got %0d want 32639 +/-8", out);
    end
  endtask

  task automatic test_saturation();
    int out, at, exp;
    bit ok;
    gain = {4'd15, 4'd15}; m_gain[0] = 15; m_gain[1] = 15;
    dac_write(2'b11, {8'hFF, 8'hFF});
    m_dac[0] = dac_val(8'hFF); m_dac[1] = dac_val(8'hFF);
    repeat (2) @(negedge clk);
    tests++;
    if (ch_dac !== {16'(m_dac[1]), 16'(m_dac[0])}) begin
      fails++;
      $display("FAIL sat_dac: got %h want 7f7f7f7f", ch_dac);
    end
    for (int f = 0; f < 40; f++) begin
      next_frame(out, ok, at);
      exp = model_frame();
      tests++;
      if (!ok || out !== exp) begin fails++; $display("FAIL sat_out: frame %0d got %0d want %0d", f, out, exp); end
      last_vld = at;
    end
    tests++;
    if (out !== 32767) begin fails++; $display("FAIL sat_clamp: got %0d want 32767", out); end
    gain = {4'd0, 4'd0}; m_gain[0] = 0; m_gain[1] = 0;
    for (int f = 0; f < 100; f++) begin
      next_frame(out, ok, at);
      exp = model_frame();
      tests++;
      if (!ok || out !== exp) begin fails++; $display("FAIL mute_out: frame %0d got %0d want %0d", f, out, exp); end
      last_vld = at;
    end
    tests++;
    if (out !== 0) begin fails++; $display("FAIL mute_final: got %0d want 0", out); end
  endtask

  task automatic test_negative();
    int out, at, exp, prev;
    bit ok;
    gain = {4'd8, 4'd8}; m_gain[0] = 8; m_gain[1] = 8;
    dac_write(2'b11, {8'h80, 8'h80});
    m_dac[0] = dac_val(8'h80); m_dac[1] = dac_val(8'h80);
    repeat (2) @(negedge clk);
    tests++;
    if (ch_dac[15:0] !== 16'(m_dac[0]) || ch_dac[15:0] !== 16'h0000) begin
      fails++; $display("FAIL neg_dac_mid: got %h want 0000", ch_dac[15:0]);
    end
    next_frame(out, ok, at);
    exp = model_frame();
    tests++;
    if (!ok || out !== exp) begin fails++; $display("FAIL neg_zero: got %0d want %0d", out, exp); end
    dac_write(2'b01, {8'h80, 8'h00});
    m_dac[0] = dac_val(8'h00);
    repeat (2) @(negedge clk);
    tests++;
    if (ch_dac[15:0] !== 16'(m_dac[0]) || ch_dac[15:0] !== 16'h8080) begin
      fails++; $display("FAIL neg_dac_min: got %h want 8080", ch_dac[15:0]);
    end
    prev = out;
    for (int f = 0; f < 80; f++) begin
      next_frame(out, ok, at);
      exp = model_frame();
      tests++;
      if (!ok || out !== exp) begin fails++; $display("FAIL neg_out: frame %0d got %0d want %0d", f, out, exp); end
      tests++;
      if (out > prev || out < -32648) begin
        fails++; $display("FAIL neg_monotonic: frame %0d got %0d after %0d", f, out, prev);
      end
      prev = out;
      last_vld = at;
    end
    tests++;
    if (out < -32640 - 8 || out > -32640 + 8) begin
      fails++; $display("FAIL neg_settle: got %0d want -32640 +/-8", out);
    end
  endtask

  task automatic test_snap_timing();
    int out, at, exp;
    bit ok;
    next_frame(out, ok, at);
    exp = model_frame();
    tests++;
    if (!ok || out !== exp) begin fails++; $display("FAIL snap_pre: got %0d want %0d", out, exp); end
    last_vld = at;
    while (cyc < at + DIV - 4*CH - 1) @(negedge clk);
    dac_write(2'b01, {8'h80, 8'hFF});
    for (int f = 0; f < 2; f++) begin
      next_frame(out, ok, at);
      exp = model_frame();
      tests++;
      if (!ok || out !== exp) begin fails++; $display("FAIL snap_frame: frame %0d got %0d want %0d", f, out, exp); end
      tests++;
      if (at - last_vld !== DIV) begin fails++; $display("FAIL snap_period: got %0d want %0d", at - last_vld, DIV); end
      last_vld = at;
      m_dac[0] = dac_val(8'hFF);
    end
  endtask

  task automatic test_random();
    int out, at, exp;
    bit ok;
    logic [15:0] d;
    logic [7:0]  g;
    logic [1:0]  mask;
    for (int f = 0; f < 10; f++) begin
      d    = 16'($urandom);
      g    = 8'($urandom);
      mask = 2'($urandom_range(1, 3));
      gain = g;
      for (int c = 0; c < CH; c++) m_gain[c] = int'(g[4*c +: 4]);
      dac_write(mask, d);
      for (int c = 0; c < CH; c++) if (mask[c]) m_dac[c] = dac_val(int'(d[8*c +: 8]));
      repeat (2) @(negedge clk);
      tests++;
      if (ch_dac !== {16'(m_dac[1]), 16'(m_dac[0])}) begin
        fails++; $display("FAIL rand_dac: frame %0d got %h want %h", f, ch_dac, {16'(m_dac[1]), 16'(m_dac[0])});
      end
      next_frame(out, ok, at);
      exp = model_frame();
      tests++;
      if (!ok || out !== exp) begin fails++; $display("FAIL rand_out: frame %0d got %0d want %0d", f, out, exp); end
      tests++;
      if (at - last_vld !== DIV) begin fails++; $display("FAIL rand_period: got %0d want %0d", at - last_vld, DIV); end
      last_vld = at;
    end
  endtask

  task automatic test_midframe_reset();
    int out, at, exp, start;
    bit ok;
    while (cyc < last_vld + DIV - 6) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < DIV; i++) begin
      @(negedge clk);
      tests++;
      if (vld !== 1'b0 || snd !== 16'sd0 || ch_dac !== 32'h0) begin
        fails++; $display("FAIL midreset_hold: vld=%b out=%0d dac=%h, want 0", vld, snd, ch_dac);
      end
    end
    rst_n = 1'b1;
    start = cyc;
    model_clear();
    next_frame(out, ok, at);
    exp = model_frame();
    tests++;
    if (!ok || (at - start) !== LAT || out !== exp) begin
      fails++; $display("FAIL midreset_restart: cycle %0d out %0d, want cycle %0d out %0d", at - start, out, LAT, exp);
    end
  endtask

  task automatic test_overrun();
    bit exp_vld[64];
    int ovr_from, busy_end, start;
    for (int t = 0; t < 64; t++) exp_vld[t] = 1'b0;
    ovr_from = 1000; busy_end = -1;
    for (int t = 0; t < 48; t++) begin
      if (t % DIV_B == DIV_B - 1) begin
        if (t > busy_end) begin
          busy_end = t + 4*CH + 2;
          exp_vld[busy_end] = 1'b1;
        end else if (ovr_from == 1000) begin
          ovr_from = t + 1;
        end
      end
    end
    gain_b = {4'd8, 4'd8};
    @(negedge clk);
    rst_b = 1'b1;
    start = cyc;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      tests++;
      if (vld_b !== exp_vld[cyc - start]) begin
        fails++; $display("FAIL ovr_vld: cycle %0d got %b want %b", cyc - start, vld_b, exp_vld[cyc - start]);
      end
      tests++;
      if (ovr_b !== ((cyc - start) >= ovr_from)) begin
        fails++; $display("FAIL ovr_flag: cycle %0d got %b want %b", cyc - start, ovr_b, (cyc - start) >= ovr_from);
      end
    end
    rst_b = 1'b0;
    @(negedge clk);
    tests++;
    if (ovr_b !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", ovr_b); end
  endtask

  initial begin
    model_clear();
    for (int c = 0; c < CH; c++) m_gain[c] = 0;
    test_reset();
    test_step();
    test_saturation();
    test_negative();
    test_snap_timing();
    test_random();
    test_midframe_reset();
    test_overrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
